// File: rtl/hack_mem_pkg.sv
// Shared definitions for the Hack memory system: address map, region decode
// and the ROM loader state encoding.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE  = 15'h0000;
  localparam logic [14:0] SCR_BASE  = 15'h4000;
  localparam logic [14:0] KBD_ADDR  = 15'h6000;
  localparam int          SCR_WORDS = 8192;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_SCR,
    REGION_KBD,
    REGION_NONE
  } region_t;

  typedef enum logic [1:0] {
    IDLE,
    HI,
    LO,
    FLUSH
  } ldr_state_t;

  // Map a CPU data address onto the target it selects.
  function automatic region_t decode_region(input logic [14:0] addr);
    region_t region;
    if (addr < SCR_BASE) begin
      region = REGION_RAM;
    end else if (addr < KBD_ADDR) begin
      region = REGION_SCR;
    end else if (addr == KBD_ADDR) begin
      region = REGION_KBD;
    end else begin
      region = REGION_NONE;
    end
    return region;
  endfunction

endpackage

// File: rtl/rom_loader.sv
// Byte-serial instruction ROM loader. Assembles big-endian byte pairs into
// 16-bit words, drives the ROM write port and holds the CPU in reset while
// a load session is active.
module rom_loader
  import hack_mem_pkg::*;
#(
  parameter int ROM_WORDS = 32768,
  parameter int ROM_AW    = $clog2(ROM_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_en,
  input  logic              i_load_valid,
  input  logic [7:0]        i_load_byte,
  output logic              o_load_ready,
  output logic [14:0]       o_load_words,
  output logic              o_cpu_rst,
  output logic              o_rom_we,
  output logic [ROM_AW-1:0] o_rom_waddr,
  output logic [15:0]       o_rom_wdata
);

  ldr_state_t        r_state;
  logic [7:0]        r_hi;
  logic [ROM_AW-1:0] r_waddr;
  logic              r_load_ready;
  logic              r_cpu_rst;
  logic              w_accept;

  // A byte is only taken while the session is still requested; dropping
  // load_en wins over a byte offered on the same edge.
  assign w_accept = i_load_en & i_load_valid & r_load_ready;

  // Loader FSM; load_ready and cpu_rst are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_hi         <= 8'h00;
      r_waddr      <= '0;
      r_load_ready <= 1'b0;
      r_cpu_rst    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every branch
      // below sees the pre-edge values of r_state/r_waddr, like real flops.
      case (r_state)
        IDLE: begin
          if (i_load_en) begin
            r_state      <= HI;
            r_waddr      <= '0;
            r_load_ready <= 1'b1;
            r_cpu_rst    <= 1'b1;
          end else begin
            r_load_ready <= 1'b0;
            r_cpu_rst    <= 1'b0;
          end
        end
        HI: begin
          if (!i_load_en) begin
            r_state      <= FLUSH;
            r_load_ready <= 1'b0;
          end else if (w_accept) begin
            r_hi    <= i_load_byte;
            r_state <= LO;
          end
        end
        LO: begin
          if (!i_load_en) begin
            r_state      <= FLUSH;
            r_load_ready <= 1'b0;
          end else if (w_accept) begin
            r_waddr <= r_waddr + 1'b1;
            r_state <= HI;
          end
        end
        FLUSH: begin
          r_state      <= IDLE;
          r_load_ready <= 1'b0;
          r_cpu_rst    <= 1'b0;
        end
        default: begin
          r_state      <= IDLE;
          r_load_ready <= 1'b0;
          r_cpu_rst    <= 1'b0;
        end
      endcase
    end
  end

  // The ROM write fires on the edge that accepts the low byte.
  assign o_rom_we     = (r_state == LO) & w_accept;
  assign o_rom_waddr  = r_waddr;
  assign o_rom_wdata  = {r_hi, i_load_byte};

  // The word count advances and wraps in lockstep with the write address.
  assign o_load_words = 15'(r_waddr);
  assign o_load_ready = r_load_ready;
  assign o_cpu_rst    = r_cpu_rst;

endmodule

// File: rtl/hack_memory_system.sv
// Responder side of the Hack CPU memory and fetch interfaces: data RAM,
// memory-mapped screen and keyboard, instruction ROM and its byte loader.
module hack_memory_system
  import hack_mem_pkg::*;
#(
  parameter int ROM_WORDS = 32768,
  parameter int RAM_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] addr_M,
  input  logic        writeM,
  input  logic [15:0] outM,
  output logic [15:0] MReg,
  input  logic [15:0] pCnt,
  output logic [15:0] instruction,
  output logic        cpu_rst,
  input  logic        load_en,
  input  logic        load_valid,
  input  logic [7:0]  load_byte,
  output logic        load_ready,
  output logic [14:0] load_words,
  input  logic        kbd_valid,
  input  logic [15:0] kbd_code,
  input  logic [12:0] scr_addr,
  output logic [15:0] scr_data
);

  localparam int ROM_AW = $clog2(ROM_WORDS);
  localparam int RAM_AW = $clog2(RAM_WORDS);

  logic [15:0] r_ram [RAM_WORDS];
  logic [15:0] r_scr [SCR_WORDS];
  logic [15:0] r_rom [ROM_WORDS];
  logic [15:0] r_kbd;
  logic [15:0] r_scr_data;

  region_t           w_region;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [12:0]       w_scr_idx;
  logic              w_ram_we;
  logic              w_scr_we;
  logic              w_kbd_ack;
  logic              w_rom_we;
  logic [ROM_AW-1:0] w_rom_waddr;
  logic [15:0]       w_rom_wdata;
  logic              w_unused_pcnt;

  assign w_region  = decode_region(addr_M);
  assign w_ram_idx = RAM_AW'(addr_M - RAM_BASE);
  assign w_scr_idx = 13'(addr_M - SCR_BASE);
  assign w_ram_we  = writeM & (w_region == REGION_RAM);
  assign w_scr_we  = writeM & (w_region == REGION_SCR);
  assign w_kbd_ack = writeM & (w_region == REGION_KBD);

  // Only the low ROM_AW bits of the fetch address select a word.
  assign w_unused_pcnt = ^pCnt;

  rom_loader #(
    .ROM_WORDS (ROM_WORDS)
  ) u_rom_loader (
    .clk          (clk),
    .rst          (rst),
    .i_load_en    (load_en),
    .i_load_valid (load_valid),
    .i_load_byte  (load_byte),
    .o_load_ready (load_ready),
    .o_load_words (load_words),
    .o_cpu_rst    (cpu_rst),
    .o_rom_we     (w_rom_we),
    .o_rom_waddr  (w_rom_waddr),
    .o_rom_wdata  (w_rom_wdata)
  );

  // Data RAM, screen RAM and ROM write ports.
  always_ff @(posedge clk) begin
    // NOTE: memory arrays carry no reset; clearing them would need a
    // multi-cycle sweep and their contents must survive rst anyway.
    if (w_ram_we) r_ram[w_ram_idx] <= outM;
    if (w_scr_we) r_scr[w_scr_idx] <= outM;
    if (w_rom_we) r_rom[w_rom_waddr] <= w_rom_wdata;
  end

  // Keyboard register: a new key code overrides a same-edge acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kbd <= 16'h0000;
    end else if (kbd_valid) begin
      r_kbd <= kbd_code;
    end else if (w_kbd_ack) begin
      r_kbd <= 16'h0000;
    end
  end

  // Display port: one-cycle read that returns the pre-edge word on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scr_data <= 16'h0000;
    end else begin
      r_scr_data <= r_scr[scr_addr];
    end
  end

  // Combinational data read mux; unmapped addresses read as zero.
  always_comb begin
    // NOTE: default first so every path assigns MReg and no latch is inferred.
    MReg = 16'h0000;
    case (w_region)
      REGION_RAM:  MReg = r_ram[w_ram_idx];
      REGION_SCR:  MReg = r_scr[w_scr_idx];
      REGION_KBD:  MReg = r_kbd;
      default:     MReg = 16'h0000;
    endcase
  end

  assign instruction = r_rom[pCnt[ROM_AW-1:0]];
  assign scr_data    = r_scr_data;

endmodule

// File: doc/hack_memory_system.md
# hack_memory_system

Responder side of the CPU's memory and fetch interfaces. It contains the following, and sits between the CPU core and the board-level peripherals:
- 16K-word data RAM, serving `addr_M`/`writeM`/`outM`/`MReg`.
- Memory-mapped screen and keyboard.
- 32K-word instruction ROM, serving `pCnt`/`instruction`.
- A byte-serial loader that fills the ROM while holding the CPU in reset.

## Interface
Parameters:
- `ROM_WORDS`, 32768: instruction memory depth. Must be a power of two, at most 32768.
- `RAM_WORDS`, 16384: data RAM depth.

Ports:
- `clk` in 1: system clock. All state changes on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `addr_M` in 15: CPU data address.
- `writeM` in 1: CPU write strobe.
- `outM` in 16: CPU write data.
- `MReg` out 16: read data at `addr_M`. Combinational.
- `pCnt` in 16: CPU fetch address. Bits [14:0] are used.
- `instruction` out 16: ROM word at `pCnt[14:0]`. Combinational.
- `cpu_rst` out 1: reset to the CPU. Registered.
- `load_en` in 1: request loader mode.
- `load_valid` in 1: a byte is offered on `load_byte`.
- `load_byte` in 8: loader data byte.
- `load_ready` out 1: loader accepts a byte this cycle.
- `load_words` out 15: number of words written since loading began.
- `kbd_valid` in 1: a new key code is present.
- `kbd_code` in 16: key code.
- `scr_addr` in 13: display read address.
- `scr_data` out 16: screen word. Registered.

## Operation
Data map, decoded on `addr_M`:
- 0x0000–0x3FFF: RAM.
- 0x4000–0x5FFF: screen RAM, 8K words.
- 0x6000: keyboard register.
- 0x6001–0x7FFF: unmapped. Reads return 0; writes are ignored.

Data writes:
- When `writeM`=1, the write takes effect at the rising edge to the decoded target.
- A write to 0x6000 clears the keyboard register to 0. This is the acknowledge.
- Reads are combinational. They return the pre-edge contents: a write becomes visible on `MReg` the cycle after it.

Keyboard register:
- Loaded with `kbd_code` on any edge where `kbd_valid`=1.
- If `kbd_valid`=1 coincides with a CPU write to 0x6000, `kbd_valid` wins.

Display port:
- `scr_data` returns the screen word at the `scr_addr` sampled at the previous edge.
- If the CPU writes the same word on that edge, `scr_data` returns the old value (read-before-write).

Loader FSM, states IDLE, HI, LO, FLUSH:
- IDLE → HI when `load_en`=1. The word address and `load_words` are cleared to 0.
- HI: on accepted byte (`load_valid` & `load_ready`), latch `load_byte` as bits [15:8] and go to LO.
- LO: on accepted byte, write {hi, byte} to ROM[waddr]. Increment `waddr` and `load_words`, then go to HI.
- HI or LO with `load_en`=0 → FLUSH. A pending high byte is discarded and no ROM write occurs.
- FLUSH → IDLE unconditionally.
- `load_ready` = 1 in HI and LO, otherwise 0.
- `waddr` wraps from ROM_WORDS-1 to 0 and overwrites from the start. `load_words` wraps identically.
- `cpu_rst` is registered as (next state ≠ IDLE). It is therefore high for every load cycle plus the FLUSH cycle.
- ROM has no CPU write path. `instruction` stays live during loading and reflects newly written words the cycle after the write.

Reset values:
- `cpu_rst`=1, state IDLE, keyboard register 0, `scr_data` 0, `load_words` 0, `load_ready` 0.
- RAM, screen and ROM contents are not reset.
- Asserting `rst` mid-load returns the FSM to IDLE at once. ROM words already written are kept.

## Timing
- Fetch and data read: 0 cycles, combinational from address.
- Data write: committed at the edge where `writeM`=1. Visible on `MReg` in the next cycle.
- Loader: one byte per cycle maximum, two bytes per word. The ROM write happens on the edge that accepts the low byte.
- `cpu_rst`:
  - Rises on the edge after `load_en` is sampled high.
  - Falls 2 edges after `load_en` is sampled low (via FLUSH).
  - After `rst` deassertion with `load_en`=0, falls at the first edge.
- Display read: 1 cycle latency.

## Structure
- Package `hack_mem_pkg` holds:
  - Region base constants: `RAM_BASE`, `SCR_BASE`, `KBD_ADDR`.
  - The region-decode function.
  - Loader state enum `ldr_state_t`.
- Sub-module `rom_loader`: the FSM, byte assembly, `waddr`/`load_words`, `cpu_rst` and the ROM write port.
- The top level holds memories, decode, the keyboard register and the display port.

## Test plan
- Data RAM: write 0x1234 to 0x0010, read next cycle → `MReg`=0x1234. Read 0x7000 → 0. Write 0x7000 then read → still 0.
- Screen: CPU writes 0xBEEF to 0x4005 while `scr_addr`=5 → `scr_data` shows the old value, then 0xBEEF one cycle later. Read 0x4005 via `MReg` → 0xBEEF.
- Keyboard:
  - `kbd_valid` with `kbd_code`=0x0041 → `MReg`@0x6000=0x0041.
  - CPU write to 0x6000 → reads 0.
  - Simultaneous `kbd_valid`(0x0042) and write → 0x0042.
- Load: `load_en`=1, stream bytes 0xAB 0xCD 0x12 0x34 with gaps → ROM[0]=0xABCD, ROM[1]=0x1234, `load_words`=2. `cpu_rst` stays high throughout and falls 2 edges after `load_en` drops. `instruction`@`pCnt`=1 is 0x1234.
- Abort: drop `load_en` after one byte of word 2 → ROM[2] unchanged, FSM passes through FLUSH, `load_words`=2.
- Async reset mid-load (state LO) → immediate IDLE, `load_ready`=0, `cpu_rst`=1. On release with `load_en`=0, `cpu_rst` falls at the first edge.
